// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared core types: branch outcome, BHT counter type and counter constants
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } branch_outcome_t;

    typedef logic [1:0] bht_counter_t;

    localparam bht_counter_t BHT_CTR_WEAK_NT = 2'b01;
    localparam bht_counter_t BHT_CTR_MAX     = 2'b11;
    localparam bht_counter_t BHT_CTR_MIN     = 2'b00;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating counter next-state function
module sat_counter2
    import mips_core_pkg::*;
(
    input  bht_counter_t    ctr,
    input  branch_outcome_t outcome,
    output bht_counter_t    next_ctr
);

    // Move one step toward the resolved direction, holding at either end.
    always_comb begin
        next_ctr = ctr;
        if (outcome == TAKEN) begin
            if (ctr != BHT_CTR_MAX) begin
                next_ctr = ctr + 2'd1;
            end
        end else begin
            if (ctr != BHT_CTR_MIN) begin
                next_ctr = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - 2-bit counter branch predictor; BRANCH_PREDICTOR_GSHARE_EN selects gshare indexing
module branch_predictor_bht
    import mips_core_pkg::*;
#(
    parameter int INDEX_WIDTH = 6,
    parameter int HIST_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic                  i_req_is_jump,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    input  logic [ADDR_WIDTH-1:0] i_req_target,
    output branch_outcome_t       o_prediction,
    output logic [ADDR_WIDTH-1:0] o_recovery_target,
    input  logic                  i_upd_valid,
    input  logic [ADDR_WIDTH-1:0] i_upd_pc,
    input  branch_outcome_t       i_upd_prediction,
    input  branch_outcome_t       i_upd_outcome,
    output logic [31:0]           o_stat_branches,
    output logic [31:0]           o_stat_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;

    // Flop array rather than SRAM so every entry can reset to weak not-taken.
    bht_counter_t bht [ENTRIES];

    logic [INDEX_WIDTH-1:0] req_idx;
    logic [INDEX_WIDTH-1:0] upd_idx;
    bht_counter_t           req_ctr;
    bht_counter_t           upd_ctr;
    bht_counter_t           upd_next;
    logic                   req_taken;

    // Only the word index bits of the update PC select an entry.
    logic unused_upd_pc_bits;
    assign unused_upd_pc_bits = ^{i_upd_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], i_upd_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [HIST_WIDTH-1:0]  ghr;
    logic [INDEX_WIDTH-1:0] ghr_ext;

    if (HIST_WIDTH < 1 || HIST_WIDTH > INDEX_WIDTH) begin : g_hist_check
        $error("HIST_WIDTH must lie in 1..INDEX_WIDTH");
    end

    assign ghr_ext = INDEX_WIDTH'(ghr);
    assign req_idx = i_req_pc[INDEX_WIDTH+1:2] ^ ghr_ext;
    assign upd_idx = i_upd_pc[INDEX_WIDTH+1:2] ^ ghr_ext;

    // Non-speculative history: shift in the resolved outcome at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (i_upd_valid) begin
            ghr <= HIST_WIDTH'({ghr, (i_upd_outcome == TAKEN)});
        end
    end
`else
    localparam int UNUSED_HIST_WIDTH = HIST_WIDTH;

    assign req_idx = i_req_pc[INDEX_WIDTH+1:2];
    assign upd_idx = i_upd_pc[INDEX_WIDTH+1:2];
`endif

    assign upd_ctr = bht[upd_idx];

    sat_counter2 u_sat (
        .ctr      (upd_ctr),
        .outcome  (i_upd_outcome),
        .next_ctr (upd_next)
    );

    // Same-cycle lookup reads the pre-update table; there is no bypass.
    always_comb begin
        req_ctr           = bht[req_idx];
        req_taken         = i_req_is_jump | req_ctr[1];
        o_prediction      = NOT_TAKEN;
        o_recovery_target = i_req_target;
        if (i_req_valid && req_taken) begin
            o_prediction      = TAKEN;
            o_recovery_target = i_req_pc + ADDR_WIDTH'(8);
        end
    end

    // Train the addressed counter from the resolved outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= BHT_CTR_WEAK_NT;
            end
        end else if (i_upd_valid) begin
            bht[upd_idx] <= upd_next;
        end
    end

    // Saturating branch and misprediction statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_stat_branches    <= '0;
            o_stat_mispredicts <= '0;
        end else if (i_upd_valid) begin
            if (o_stat_branches != 32'hFFFF_FFFF) begin
                o_stat_branches <= o_stat_branches + 32'd1;
            end
            if ((i_upd_prediction != i_upd_outcome) &&
                (o_stat_mispredicts != 32'hFFFF_FFFF)) begin
                o_stat_mispredicts <= o_stat_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - self-checking bench for branch_predictor_bht
module tb_branch_predictor_bht;
    import mips_core_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_is_jump;
    logic [31:0]     req_pc;
    logic [31:0]     req_target;
    branch_outcome_t prediction;
    logic [31:0]     recovery_target;
    logic            upd_valid;
    logic [31:0]     upd_pc;
    branch_outcome_t upd_prediction;
    branch_outcome_t upd_outcome;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] PC_A  = 32'h0040_0010;
    localparam logic [31:0] TGT_A = 32'h0040_0100;
    localparam logic [31:0] PC_B  = 32'h0040_0040;
    localparam logic [31:0] TGT_B = 32'h0040_0400;
    localparam logic [31:0] PC_J  = 32'h0040_0020;
    localparam logic [31:0] TGT_J = 32'h0040_0200;
    localparam logic [31:0] PC_W  = 32'hFFFF_FFFC;
    localparam logic [31:0] TGT_W = 32'h0000_1000;

    always #5 clk = ~clk;

    branch_predictor_bht #(.INDEX_WIDTH(6), .HIST_WIDTH(6)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_req_valid        (req_valid),
        .i_req_is_jump      (req_is_jump),
        .i_req_pc           (req_pc),
        .i_req_target       (req_target),
        .o_prediction       (prediction),
        .o_recovery_target  (recovery_target),
        .i_upd_valid        (upd_valid),
        .i_upd_pc           (upd_pc),
        .i_upd_prediction   (upd_prediction),
        .i_upd_outcome      (upd_outcome),
        .o_stat_branches    (stat_branches),
        .o_stat_mispredicts (stat_mispredicts)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: counters as integers 0..3, counts as plain saturating integers.
    int     mdl_ctr [64];
    int     mdl_ghr;
    longint mdl_br;
    longint mdl_mp;

    function automatic int mdl_idx(input logic [31:0] pc);
        int i;
        i = int'((pc / 4) % 64);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        i = i ^ mdl_ghr;
`endif
        return i;
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl_update
        int k;
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mdl_ctr[i] = 1;
            mdl_ghr = 0;
            mdl_br  = 0;
            mdl_mp  = 0;
        end else if (upd_valid) begin
            k = mdl_idx(upd_pc);
            if (upd_outcome == TAKEN) begin
                if (mdl_ctr[k] < 3) mdl_ctr[k] = mdl_ctr[k] + 1;
            end else begin
                if (mdl_ctr[k] > 0) mdl_ctr[k] = mdl_ctr[k] - 1;
            end
            if (mdl_br < 64'hFFFF_FFFF) mdl_br = mdl_br + 1;
            if (upd_prediction != upd_outcome && mdl_mp < 64'hFFFF_FFFF) mdl_mp = mdl_mp + 1;
            mdl_ghr = ((mdl_ghr * 2) + ((upd_outcome == TAKEN) ? 1 : 0)) % 64;
        end
    end

    // Compare every mid-cycle sample against the model.
    always @(negedge clk) begin : compare
        logic        exp_taken;
        logic [31:0] exp_tgt;
        if (rst_n === 1'b1) begin
            exp_taken = req_valid && (req_is_jump || mdl_ctr[mdl_idx(req_pc)] >= 2);
            exp_tgt   = exp_taken ? req_pc + 32'd8 : req_target;
            check("model_pred", prediction, exp_taken);
            check("model_target", recovery_target, exp_tgt);
            check("model_branches", stat_branches, mdl_br);
            check("model_mispredicts", stat_mispredicts, mdl_mp);
        end
    end

    task automatic drive(input logic rv, input logic rj, input logic [31:0] rpc, input logic [31:0] rtgt,
                         input logic uv, input logic [31:0] upc, input branch_outcome_t up,
                         input branch_outcome_t uo);
        @(posedge clk);
        #1;
        req_valid      = rv;
        req_is_jump    = rj;
        req_pc         = rpc;
        req_target     = rtgt;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_prediction = up;
        upd_outcome    = uo;
        @(negedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [31:0] tgt);
        drive(1'b1, 1'b0, pc, tgt, 1'b0, 32'h0, NOT_TAKEN, NOT_TAKEN);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] rnd_pcs [4];

    initial begin : stim
        req_valid      = 1'b0;
        req_is_jump    = 1'b0;
        req_pc         = '0;
        req_target     = '0;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_prediction = NOT_TAKEN;
        upd_outcome    = NOT_TAKEN;
        rnd_pcs[0] = PC_A;
        rnd_pcs[1] = 32'h0040_0110;
        rnd_pcs[2] = 32'h0040_0014;
        rnd_pcs[3] = PC_W;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #22;
        @(negedge clk);
        rst_n = 1'b1;

        lookup(PC_A, TGT_A);
        check("reset_pred", prediction, NOT_TAKEN);
        check("reset_target", recovery_target, TGT_A);
        check("reset_branches", stat_branches, 0);
        check("reset_mispredicts", stat_mispredicts, 0);

`ifndef BRANCH_PREDICTOR_GSHARE_EN
        drive(1'b1, 1'b0, PC_A, TGT_A, 1'b1, PC_A, NOT_TAKEN, TAKEN);
        check("train0_pred", prediction, NOT_TAKEN);
        drive(1'b1, 1'b0, PC_A, TGT_A, 1'b1, PC_A, NOT_TAKEN, TAKEN);
        check("train1_pred", prediction, TAKEN);
        check("train1_target", recovery_target, 32'h0040_0018);
        lookup(PC_A, TGT_A);
        check("train_mispredicts", stat_mispredicts, 2);
        check("train_branches", stat_branches, 2);
        check("train_strong_pred", prediction, TAKEN);

        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, PC_B, TAKEN, TAKEN);
        end
        drive(1'b1, 1'b0, PC_B, TGT_B, 1'b1, PC_B, TAKEN, NOT_TAKEN);
        check("sat_top_pred", prediction, TAKEN);
        drive(1'b1, 1'b0, PC_B, TGT_B, 1'b1, PC_B, TAKEN, NOT_TAKEN);
        check("collide_same_pred", prediction, TAKEN);
        check("collide_same_target", recovery_target, 32'h0040_0048);
        lookup(PC_B, TGT_B);
        check("collide_next_pred", prediction, NOT_TAKEN);
        check("collide_next_target", recovery_target, TGT_B);
        check("collide_branches", stat_branches, 9);
        check("collide_mispredicts", stat_mispredicts, 4);

        drive(1'b1, 1'b1, PC_J, TGT_J, 1'b0, 32'h0, NOT_TAKEN, NOT_TAKEN);
        check("jump_pred", prediction, TAKEN);
        check("jump_target", recovery_target, 32'h0040_0028);
        lookup(PC_J, TGT_J);
        check("jump_no_train_pred", prediction, NOT_TAKEN);
        check("jump_no_train_branches", stat_branches, 9);

        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, PC_W, NOT_TAKEN, TAKEN);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, PC_W, NOT_TAKEN, TAKEN);
        lookup(PC_W, TGT_W);
        check("wrap_pred", prediction, TAKEN);
        check("wrap_target", recovery_target, 32'h0000_0004);

        drive(1'b0, 1'b1, PC_A, TGT_A, 1'b0, 32'h0, NOT_TAKEN, NOT_TAKEN);
        check("idle_pred", prediction, NOT_TAKEN);
        check("idle_target", recovery_target, TGT_A);
`else
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, PC_A, TGT_A, 1'b1, PC_A, TAKEN,
                  (i % 2 == 1) ? TAKEN : NOT_TAKEN);
        end
        lookup(PC_A, TGT_A);
        check("gshare_ghr", dut.ghr, 6'b010101);
        drive(1'b1, 1'b0, PC_A, TGT_A, 1'b1, PC_A, TAKEN, TAKEN);
        rst_n = 1'b0;
        upd_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        lookup(PC_A, TGT_A);
        check("gshare_reset_ghr", dut.ghr, 0);
`endif

        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                  rnd_pcs[$urandom_range(0, 3)], $urandom,
                  1'($urandom_range(0, 2) != 0), rnd_pcs[$urandom_range(0, 3)],
                  branch_outcome_t'($urandom_range(0, 1)), branch_outcome_t'($urandom_range(0, 1)));
        end

        drive(1'b1, 1'b0, PC_A, TGT_A, 1'b1, PC_A, NOT_TAKEN, TAKEN);
        rst_n     = 1'b0;
        upd_valid = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        lookup(PC_A, TGT_A);
        check("midreset_pred", prediction, NOT_TAKEN);
        check("midreset_target", recovery_target, TGT_A);
        check("midreset_branches", stat_branches, 0);
        check("midreset_mispredicts", stat_mispredicts, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Dynamic branch predictor serving the decode stage: for every decoded branch it returns a taken/not-taken prediction and the recovery address carried down the pipe, and it trains a table of 2-bit saturating counters from branch results resolved in EX. Lookup is combinational, so decode gets its answer in the same cycle. Training is registered. The block sits beside the decode-stage glue and closes the loop from the EX-stage branch result back into decode.

## Interface
- `INDEX_WIDTH`, 6: log2 of the number of counter entries (64).
- `HIST_WIDTH`, 6: width of the global history register; must be ≤ `INDEX_WIDTH`; used only with `GSHARE_EN`.
- Port `clk`, input, 1: the single clock.
- Port `rst_n`, input, 1: asynchronous, active-low reset.
- Port `i_req_valid`, input, 1: decode holds a conditional branch or a jump.
- Port `i_req_is_jump`, input, 1: the request is an unconditional jump.
- Port `i_req_pc`, input, `ADDR_WIDTH`: PC of the branch instruction.
- Port `i_req_target`, input, `ADDR_WIDTH`: computed branch/jump target.
- Port `o_prediction`, output, `branch_outcome_t`: `TAKEN` or `NOT_TAKEN`.
- Port `o_recovery_target`, output, `ADDR_WIDTH`: the address to redirect to on a misprediction.
- Port `i_upd_valid`, input, 1: a resolved conditional branch is present this cycle.
- Port `i_upd_pc`, input, `ADDR_WIDTH`: PC of the resolved branch.
- Port `i_upd_prediction`, input, `branch_outcome_t`: the prediction that was made for it.
- Port `i_upd_outcome`, input, `branch_outcome_t`: the actual outcome.
- Port `o_stat_branches`, output, 32: count of resolved conditional branches.
- Port `o_stat_mispredicts`, output, 32: count of resolved branches with prediction ≠ outcome.

## Operation
- **Index.** `idx = pc[INDEX_WIDTH+1:2]`, with word-aligned PCs. Under `GSHARE_EN` the index is XORed with the history (see Configuration).
- **Counters.** Each entry is a 2-bit counter:
  - 00 = strong not-taken.
  - 01 = weak not-taken.
  - 10 = weak taken.
  - 11 = strong taken.
  - A counter predicts `TAKEN` when its MSB is 1.
- **Lookup, combinational.**
  - If `i_req_is_jump` is set, `o_prediction = TAKEN` and the table is not consulted.
  - Otherwise `o_prediction` is the MSB of the indexed counter.
  - When `i_req_valid = 0`, `o_prediction = NOT_TAKEN` and `o_recovery_target = i_req_target`.
- **Recovery target.**
  - Predicted taken: `o_recovery_target = i_req_pc + 8` (the fall-through address after the delay slot).
  - Predicted not-taken: `o_recovery_target = i_req_target`.
  - The `+8` addition wraps modulo 2^`ADDR_WIDTH`.
- **Update, on the clock edge when `i_upd_valid = 1`.**
  - If the outcome is `TAKEN`, the counter at `idx(i_upd_pc)` increments, saturating at 11.
  - If the outcome is `NOT_TAKEN`, it decrements, saturating at 00.
  - Jumps never reach the update port; EX filters them out.
- **Statistics.**
  - `o_stat_branches` increments on each update.
  - `o_stat_mispredicts` increments when `i_upd_prediction ≠ i_upd_outcome`.
  - Both saturate at 0xFFFF_FFFF; they do not wrap.
- **Simultaneous lookup and update to the same index.** The lookup sees the pre-update value; there is no bypass. The new value is visible from the next cycle.

## Timing
- Lookup latency is 0 cycles; it is purely combinational from the `i_req_*` inputs and the table state.
- Update latency is 1 cycle: the counter, history and statistics change on the first `clk` rise with `i_upd_valid = 1`.
- Reset values, applied asynchronously on `rst_n` = 0:
  - Every counter = 01 (weak not-taken).
  - History = 0.
  - `o_stat_branches` = 0 and `o_stat_mispredicts` = 0.
  - The combinational outputs then follow the reset table state, so `o_prediction = NOT_TAKEN` for every non-jump request.
- Reset asserted mid-operation: the update pending that cycle is discarded. Training resumes on the first edge after `rst_n` rises.
- There is no handshake and no stall. The block never back-pressures, and one update per cycle is accepted.

## Configuration
- The single compile-time macro is `BRANCH_PREDICTOR_GSHARE_EN`.
- **Defined:** gshare indexing.
  - The index becomes `pc[INDEX_WIDTH+1:2] ^ {{(INDEX_WIDTH-HIST_WIDTH){1'b0}}, ghr}`.
  - `ghr` is a `HIST_WIDTH`-bit register that shifts in the actual outcome (1 = taken) at the LSB on each update. It is non-speculative.
  - Lookup and update both use the current `ghr`.
- **Undefined:** bimodal, PC-only indexing. No history register is instantiated and `HIST_WIDTH` is ignored.

## Structure
- Package `mips_core_pkg` holds:
  - `branch_outcome_t`, which already exists.
  - A new `bht_counter_t` (2 bits).
  - Localparams `BHT_CTR_WEAK_NT = 2'b01`, `BHT_CTR_MAX = 2'b11` and `BHT_CTR_MIN = 2'b00`.
- Sub-module `sat_counter2` holds the pure 2-bit saturating next-state function: counter in, outcome in, counter out. The predictor instantiates it once on the update path.
- The counter table is a flop array, because async reset to 01 is required; no SRAM macro is used.

## Test plan
- **Reset.** Drive `rst_n` = 0, then release it.
  - Lookup `pc=0x0040_0010`, `target=0x0040_0100` returns `NOT_TAKEN` with `o_recovery_target = 0x0040_0100`.
  - Both stat counters read 0.
- **Training.** Apply two updates to `pc=0x0040_0010` with outcome `TAKEN` and prediction `NOT_TAKEN`.
  - After the first update the counter is 10 and the next-cycle lookup returns `TAKEN` with `o_recovery_target = 0x0040_0018`.
  - `o_stat_mispredicts` = 2.
- **Saturation.** Apply 5 `TAKEN` updates to one PC, then 1 `NOT_TAKEN`.
  - The counter reaches 11, then 10.
  - The lookup still returns `TAKEN`.
- **Same-cycle collision.** Lookup and `NOT_TAKEN` update hit a counter at 10 in the same cycle.
  - The lookup that cycle returns `TAKEN`.
  - The following cycle returns `NOT_TAKEN`.
- **Jump.** `i_req_is_jump = 1` with `pc=0x0040_0020`, `target=0x0040_0200`.
  - The result is `TAKEN` with `o_recovery_target = 0x0040_0028`, regardless of table state.
  - No table change occurs.
- **Gshare (with `BRANCH_PREDICTOR_GSHARE_EN`).** Apply alternating T/NT updates to one PC.
  - `ghr` becomes `6'b010101` after six updates.
  - The two PCs aliasing under bimodal map to distinct entries.
  - Mid-sequence reset clears `ghr` to 0.
